sya_act_feeder: RTL and testbench
=================================

Name: sya_act_feeder

Overview:
Left-edge transmitter for the systolic array. Accepts one activation vector per beat (one element per array row) from the activation buffer and drives every row's left-edge PE inputs: valid, advance (rdy), activation and accumulation-reset. Row r is delayed by r advances to produce the diagonal skew the array needs. Row 0 of each new accumulation group carries the acc_reset tag, and the block flushes the skew pipeline before reporting done.

Parameters:
NUM_ROW, 16, number of array rows fed (>=1)
ACT_WIDTH, 8, activation element width
CNT_WIDTH, 12, width of the job-configuration counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_start  in  1  single-cycle job start pulse; ignored while busy=1
cfg_k_len  in  CNT_WIDTH  beats per accumulation group; 0 is treated as 1
cfg_num_grp  in  CNT_WIDTH  groups per job; 0 is treated as 1
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the job is fully emitted
in_vld  in  1  buffer beat valid
in_rdy  out  1  feeder accepts the beat
in_act  in  NUM_ROW*ACT_WIDTH  row r at [r*ACT_WIDTH +: ACT_WIDTH]
arr_en  in  1  array may advance this cycle (backpressure when 0)
out_rdy  out  1  array-wide advance to all PEs
out_vld  out  NUM_ROW  per-row valid into PE
out_act  out  NUM_ROW*ACT_WIDTH  per-row skewed activation
out_acc_reset  out  NUM_ROW  per-row skewed accumulation-reset

Behaviour:
- States: IDLE, FEED, FLUSH. Reset state is IDLE. All registers reset to 0, including busy, done, in_rdy, out_rdy, out_vld, out_act and out_acc_reset.
- IDLE -> FEED: on cfg_start. The feeder latches cfg_k_len and cfg_num_grp (0 -> 1) and clears k_cnt and g_cnt.
- Advance: adv = arr_en and (state is FEED or FLUSH). out_rdy = adv, combinational.
- in_rdy = arr_en and state == FEED. A beat is accepted when in_vld and in_rdy.
- Skew pipeline:
  - Shifts only on adv; all skew registers hold when adv=0.
  - On adv in FEED, the entry is the accepted beat, or a bubble (vld=0) if in_vld=0.
  - In FLUSH, every entry is a bubble.
  - An entry entering at cycle t is output on row r at cycle t+1+r (registered, no combinational in->out path).
- Tag: acc_reset = (k_cnt == 0) on each accepted beat. The vld, act and acc_reset bits of a beat are skewed together per row. Bubbles carry acc_reset=0 and leave act unchanged/don't-care.
- Counters advance only on accept:
  - k_cnt increments, wrapping to 0 at k_len-1.
  - On wrap, g_cnt increments.
- FEED -> FLUSH: on the accept of the last beat of the last group.
  - If NUM_ROW == 1, go directly to IDLE with done instead.
- FLUSH:
  - f_cnt counts adv cycles.
  - On the adv that makes f_cnt reach NUM_ROW-1, go to IDLE and pulse done next cycle. Done is coincident with the last beat appearing on row NUM_ROW-1.
  - arr_en=0 in FLUSH stalls the flush, which delays done.
- Done cycle: busy=0, done=1, out_vld holds its last-shifted values. In the cycle after done, all out_vld bits clear to 0. out_act and out_acc_reset hold.
- cfg_start in the done cycle is accepted, giving back-to-back jobs. The stale out_vld clear still applies.
- Async reset at any point: immediate return to IDLE with all outputs 0. No done is produced for the aborted job.

Test Plan:
1. Basic job: NUM_ROW=4, k_len=3, num_grp=2, in_vld=1 and arr_en=1 throughout, cfg_start at cycle 0. Required response:
   - beats accepted cycles 1-6;
   - row0 out_vld=1 cycles 2-7, with acc_reset=1 at cycles 2 and 5;
   - row3 out_vld=1 cycles 5-10, acc_reset at cycles 5 and 8;
   - done=1 and busy=0 at cycle 10; all out_vld=0 at cycle 11.
2. Backpressure: same job with arr_en=0 in cycles 3-4. Required response:
   - in_rdy=0 and out_rdy=0 in cycles 3-4;
   - all out_* hold and counters hold;
   - every subsequent event shifts by 2 cycles and done lands at cycle 12.
3. Bubbles: in_vld=0 at cycle 2 only. Required response:
   - a vld=0 slot appears at row0 cycle 3 and row3 cycle 6;
   - the 6 beats keep tags on beats 1 and 4;
   - done lands at cycle 11.
4. Config edges: cfg_k_len=0, cfg_num_grp=3. Required response:
   - every beat is emitted with acc_reset=1;
   - exactly 3 beats are accepted;
   - a second cfg_start at cycle 2 is ignored, with no counter reload.
5. Reset mid-FLUSH: rst_n low at cycle 8 of scenario 1. Required response:
   - all outputs are 0 immediately;
   - busy=0 and done never asserts;
   - a new cfg_start runs normally.
6. NUM_ROW=1, k_len=2, num_grp=1. Required response:
   - FLUSH is skipped;
   - the last beat is accepted at cycle 2;
   - out_vld=1 and done=1 together at cycle 3.

Source files
------------

// File: rtl/sya_act_feeder_if.sv
// Handshake and data bundle between the activation buffer, the feeder and the
// left edge of the systolic array.
interface sya_act_feeder_if #(
  parameter int NUM_ROW   = 16,
  parameter int ACT_WIDTH = 8,
  parameter int CNT_WIDTH = 12
);
  logic                         cfg_start;
  logic [CNT_WIDTH-1:0]         cfg_k_len;
  logic [CNT_WIDTH-1:0]         cfg_num_grp;
  logic                         busy;
  logic                         done;
  logic                         in_vld;
  logic                         in_rdy;
  logic [NUM_ROW*ACT_WIDTH-1:0] in_act;
  logic                         arr_en;
  logic                         out_rdy;
  logic [NUM_ROW-1:0]           out_vld;
  logic [NUM_ROW*ACT_WIDTH-1:0] out_act;
  logic [NUM_ROW-1:0]           out_acc_reset;

  // Job controller / buffer / array side
  modport master (
    output cfg_start, cfg_k_len, cfg_num_grp, in_vld, in_act, arr_en,
    input  busy, done, in_rdy, out_rdy, out_vld, out_act, out_acc_reset
  );

  // Feeder side
  modport slave (
    input  cfg_start, cfg_k_len, cfg_num_grp, in_vld, in_act, arr_en,
    output busy, done, in_rdy, out_rdy, out_vld, out_act, out_acc_reset
  );
endinterface

// File: rtl/sya_act_feeder.sv
// Left-edge feeder for the systolic array: accepts one activation vector per
// beat, skews row r by r advances, tags the first beat of each accumulation
// group and flushes the skew before signalling done.
module sya_act_feeder #(
  parameter int NUM_ROW   = 16,
  parameter int ACT_WIDTH = 8,
  parameter int CNT_WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  sya_act_feeder_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_FLUSH} state_t;

  localparam int FW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  // Flush ends on the advance that brings f_cnt to NUM_ROW-1.
  localparam logic [FW-1:0] F_LAST = (NUM_ROW > 1) ? FW'(NUM_ROW - 2) : '0;

  state_t               r_state, w_state_next;
  logic [CNT_WIDTH-1:0] r_k_len, w_k_len_next;
  logic [CNT_WIDTH-1:0] r_num_grp, w_num_grp_next;
  logic [CNT_WIDTH-1:0] r_k_cnt, w_k_cnt_next;
  logic [CNT_WIDTH-1:0] r_g_cnt, w_g_cnt_next;
  logic [FW-1:0]        r_f_cnt, w_f_cnt_next;
  logic                 r_done, w_done_next;

  logic w_adv, w_in_rdy, w_accept, w_k_wrap, w_last_beat, w_tag;

  assign w_adv       = bus.arr_en && (r_state == ST_FEED || r_state == ST_FLUSH);
  assign w_in_rdy    = bus.arr_en && (r_state == ST_FEED);
  assign w_accept    = bus.in_vld && w_in_rdy;
  assign w_k_wrap    = (r_k_cnt == r_k_len - CNT_WIDTH'(1));
  assign w_last_beat = w_k_wrap && (r_g_cnt == r_num_grp - CNT_WIDTH'(1));
  assign w_tag       = (r_k_cnt == '0);

  assign bus.in_rdy  = w_in_rdy;
  assign bus.out_rdy = w_adv;
  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.done    = r_done;

  // State and job counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_k_len   <= '0;
      r_num_grp <= '0;
      r_k_cnt   <= '0;
      r_g_cnt   <= '0;
      r_f_cnt   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_k_len   <= w_k_len_next;
      r_num_grp <= w_num_grp_next;
      r_k_cnt   <= w_k_cnt_next;
      r_g_cnt   <= w_g_cnt_next;
      r_f_cnt   <= w_f_cnt_next;
      r_done    <= w_done_next;
    end
  end

  // Next-state logic: job load, beat counting and flush countdown
  always_comb begin
    w_state_next   = r_state;
    w_k_len_next   = r_k_len;
    w_num_grp_next = r_num_grp;
    w_k_cnt_next   = r_k_cnt;
    w_g_cnt_next   = r_g_cnt;
    w_f_cnt_next   = r_f_cnt;
    w_done_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cfg_start) begin
          w_state_next   = ST_FEED;
          w_k_len_next   = (bus.cfg_k_len == '0) ? CNT_WIDTH'(1) : bus.cfg_k_len;
          w_num_grp_next = (bus.cfg_num_grp == '0) ? CNT_WIDTH'(1) : bus.cfg_num_grp;
          w_k_cnt_next   = '0;
          w_g_cnt_next   = '0;
        end
      end
      ST_FEED: begin
        if (w_accept) begin
          if (w_k_wrap) begin
            w_k_cnt_next = '0;
            w_g_cnt_next = r_g_cnt + CNT_WIDTH'(1);
          end else begin
            w_k_cnt_next = r_k_cnt + CNT_WIDTH'(1);
          end
          if (w_last_beat) begin
            // A single row has no skew to drain.
            if (NUM_ROW == 1) begin
              w_state_next = ST_IDLE;
              w_done_next  = 1'b1;
            end else begin
              w_state_next = ST_FLUSH;
              w_f_cnt_next = '0;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (w_adv) begin
          w_f_cnt_next = r_f_cnt + FW'(1);
          if (r_f_cnt == F_LAST) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Per-row skew chains: row gi is gi+1 registers deep.
  for (genvar gi = 0; gi < NUM_ROW; gi++) begin : g_row
    logic [ACT_WIDTH-1:0] r_act_sh [0:gi];
    logic [gi:0]          r_vld_sh;
    logic [gi:0]          r_tag_sh;

    // Shift on advance; drop stale valids in the cycle after done
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld_sh <= '0;
        r_tag_sh <= '0;
        for (int d = 0; d <= gi; d++) r_act_sh[d] <= '0;
      end else if (w_adv) begin
        r_vld_sh[0] <= w_accept;
        r_tag_sh[0] <= w_accept && w_tag;
        if (w_accept) r_act_sh[0] <= bus.in_act[gi*ACT_WIDTH +: ACT_WIDTH];
        for (int d = 1; d <= gi; d++) begin
          r_vld_sh[d] <= r_vld_sh[d-1];
          r_tag_sh[d] <= r_tag_sh[d-1];
          r_act_sh[d] <= r_act_sh[d-1];
        end
      end else if (r_done) begin
        r_vld_sh <= '0;
      end
    end

    assign bus.out_vld[gi]                          = r_vld_sh[gi];
    assign bus.out_acc_reset[gi]                    = r_tag_sh[gi];
    assign bus.out_act[gi*ACT_WIDTH +: ACT_WIDTH]   = r_act_sh[gi];
  end

endmodule

// File: tb/tb_sya_act_feeder.sv
// Scoreboard bench for sya_act_feeder: a 4-row instance for the main jobs and
// a 1-row instance for the no-flush case.
module tb_sya_act_feeder;

  typedef struct {
    int         cyc;
    logic [7:0] act;
    logic       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   sel = 0;
  int   total = 0;
  int   bad = 0;

  exp_t q[5][$];      // 0..3: rows of the 4-row instance, 4: the 1-row instance
  int   dq[2][$];     // expected done cycles per instance
  logic prev_adv_a = 1'b0;
  logic prev_adv_b = 1'b0;

  sya_act_feeder_if #(.NUM_ROW(4), .ACT_WIDTH(8), .CNT_WIDTH(12)) ifa ();
  sya_act_feeder_if #(.NUM_ROW(1), .ACT_WIDTH(8), .CNT_WIDTH(12)) ifb ();

  sya_act_feeder #(.NUM_ROW(4), .ACT_WIDTH(8), .CNT_WIDTH(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  sya_act_feeder #(.NUM_ROW(1), .ACT_WIDTH(8), .CNT_WIDTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed signals of the instance under test
  logic       t_in_rdy, t_out_rdy, t_busy, t_done;
  logic [3:0] t_vld;
  always_comb begin
    if (sel == 0) begin
      t_in_rdy = ifa.in_rdy; t_out_rdy = ifa.out_rdy;
      t_busy = ifa.busy; t_done = ifa.done; t_vld = ifa.out_vld;
    end else begin
      t_in_rdy = ifb.in_rdy; t_out_rdy = ifb.out_rdy;
      t_busy = ifb.busy; t_done = ifb.done; t_vld = {3'b000, ifb.out_vld};
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_pop(input int idx, input logic [7:0] act, input logic tag);
    exp_t e;
    total++;
    if (q[idx].size() == 0) begin
      bad++;
      $display("FAIL beat_unexpected: slot=%0d cycle=%0d act=%h tag=%b, none expected", idx, cyc, act, tag);
    end else begin
      e = q[idx].pop_front();
      if (e.cyc != cyc || e.act !== act || e.tag !== tag) begin
        bad++;
        $display("FAIL beat slot=%0d: got cyc=%0d act=%h tag=%b expected cyc=%0d act=%h tag=%b",
                 idx, cyc, act, tag, e.cyc, e.act, e.tag);
      end else begin
        $display("beat slot=%0d cyc=%0d act=%h tag=%b ok", idx, cyc, act, tag);
      end
    end
  endtask

  task automatic check_done(input int inst, input logic busy);
    int ec;
    total++;
    if (dq[inst].size() == 0) begin
      bad++;
      $display("FAIL done_unexpected: inst=%0d cycle=%0d, no done expected", inst, cyc);
    end else begin
      ec = dq[inst].pop_front();
      if (ec != cyc || busy !== 1'b0) begin
        bad++;
        $display("FAIL done inst=%0d: got cyc=%0d busy=%b expected cyc=%0d busy=0", inst, cyc, busy, ec);
      end else begin
        $display("done inst=%0d cyc=%0d ok", inst, cyc);
      end
    end
  endtask

  // Monitor: a row shows a new entry when the previous cycle advanced
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_adv_a = 1'b0;
      prev_adv_b = 1'b0;
    end else begin
      for (int r = 0; r < 4; r++)
        if (prev_adv_a && ifa.out_vld[r])
          check_pop(r, ifa.out_act[r*8 +: 8], ifa.out_acc_reset[r]);
      if (prev_adv_b && ifb.out_vld[0]) check_pop(4, ifb.out_act, ifb.out_acc_reset[0]);
      if (ifa.done) check_done(0, ifa.busy);
      if (ifb.done) check_done(1, ifb.busy);
      prev_adv_a = ifa.out_rdy;
      prev_adv_b = ifb.out_rdy;
    end
  end

  // Cycle of the n-th advance after advance cycle c (n=0 gives c itself)
  function automatic int nth_adv(input logic [31:0] m, input int c, input int n);
    int k = c;
    int cnt = 0;
    while (cnt < n && k < 31) begin
      k++;
      if (m[k]) cnt++;
    end
    return k;
  endfunction

  // One job: masks are indexed by cycle relative to the cfg_start cycle.
  task automatic run_job(input int kl, input int ng,
                         input logic [31:0] stall_m, input logic [31:0] bub_m,
                         input logic [31:0] acc_m, input logic [31:0] adv_m,
                         input logic [31:0] tag_m, input int done_rel,
                         input int extra_start, input int cut);
    int         base, nrow, last, ec;
    logic [31:0] got_acc;
    exp_t       e;
    nrow = (sel == 0) ? 4 : 1;
    last = (cut < done_rel) ? cut + 2 : done_rel + 2;
    got_acc = '0;
    @(posedge clk); #1;
    base = cyc;
    for (int c = 0; c < 32; c++) begin
      if (acc_m[c]) begin
        for (int r = 0; r < nrow; r++) begin
          ec = nth_adv(adv_m, c, r) + 1;
          if (ec < cut) begin
            e.cyc = base + ec;
            e.act = {c[3:0], r[3:0]};
            e.tag = tag_m[c];
            q[(sel == 0) ? r : 4].push_back(e);
          end
        end
      end
    end
    if (done_rel < cut) dq[sel].push_back(base + done_rel);
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == cut + 2) rst_n = 1'b1;
      ifa.cfg_start   = (sel == 0) && (c == 0 || c == extra_start);
      ifb.cfg_start   = (sel == 1) && (c == 0 || c == extra_start);
      ifa.cfg_k_len   = 12'(kl);   ifb.cfg_k_len   = 12'(kl);
      ifa.cfg_num_grp = 12'(ng);   ifb.cfg_num_grp = 12'(ng);
      ifa.arr_en      = !stall_m[c]; ifb.arr_en    = !stall_m[c];
      ifa.in_vld      = !bub_m[c];   ifb.in_vld    = !bub_m[c];
      for (int r = 0; r < 4; r++) ifa.in_act[r*8 +: 8] = {c[3:0], r[3:0]};
      ifb.in_act = {c[3:0], 4'h0};
      if (c == cut) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs",
            {20'd0, ifa.busy, ifa.done, ifa.in_rdy, ifa.out_rdy, ifa.out_vld, ifa.out_acc_reset, ifa.out_act},
            64'd0);
      end
      @(negedge clk);
      if (!bub_m[c] && t_in_rdy) got_acc[c] = 1'b1;
      if (stall_m[c]) chk("stall_rdy", {62'd0, t_in_rdy, t_out_rdy}, 64'd0);
      if (done_rel < cut && c == done_rel + 1)
        chk("vld_clear_after_done", {58'd0, t_busy, t_done, t_vld}, 64'd0);
    end
    chk("accept_cycles", {32'd0, got_acc}, {32'd0, acc_m});
    for (int i = 0; i < 5; i++) chk("beat_queue_empty", 64'(q[i].size()), 64'd0);
    chk("done_queue_empty", 64'(dq[sel].size()), 64'd0);
  endtask

  initial begin
    ifa.cfg_start = 1'b0; ifa.cfg_k_len = '0; ifa.cfg_num_grp = '0;
    ifa.in_vld = 1'b0; ifa.in_act = '0; ifa.arr_en = 1'b0;
    ifb.cfg_start = 1'b0; ifb.cfg_k_len = '0; ifb.cfg_num_grp = '0;
    ifb.in_vld = 1'b0; ifb.in_act = '0; ifb.arr_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state_a",
        {20'd0, ifa.busy, ifa.done, ifa.in_rdy, ifa.out_rdy, ifa.out_vld, ifa.out_acc_reset, ifa.out_act},
        64'd0);
    chk("reset_state_b",
        {51'd0, ifb.busy, ifb.done, ifb.in_rdy, ifb.out_rdy, ifb.out_vld, ifb.out_acc_reset, ifb.out_act},
        64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ifa.arr_en = 1'b1;

    sel = 0;
    // Basic job: k_len=3, num_grp=2
    run_job(3, 2, 32'h0, 32'h0, 32'h7E, 32'h3FE, 32'h12, 10, -1, 99);
    // Backpressure in cycles 3-4
    run_job(3, 2, 32'h18, 32'h0, 32'h1E6, 32'hFE6, 32'h42, 12, -1, 99);
    // Bubble at cycle 2
    run_job(3, 2, 32'h0, 32'h4, 32'hFA, 32'h7FE, 32'h22, 11, -1, 99);
    // k_len=0 acts as 1, num_grp=3, second start at cycle 2 ignored
    run_job(0, 3, 32'h0, 32'h0, 32'hE, 32'h7E, 32'hE, 7, 2, 99);
    // Reset at cycle 8 during flush, then a normal job
    run_job(3, 2, 32'h0, 32'h0, 32'h7E, 32'h3FE, 32'h12, 10, -1, 8);
    run_job(3, 2, 32'h0, 32'h0, 32'h7E, 32'h3FE, 32'h12, 10, -1, 99);

    sel = 1;
    // Single row: no flush, done with the last beat
    run_job(2, 1, 32'h0, 32'h0, 32'h6, 32'h6, 32'h2, 3, -1, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
